// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: STAGES ripple segments with valid/ready flow control.
// Define PIPELINED_ADDSUB_SAT_EN to saturate s on signed overflow.
module pipelined_addsub #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);
   localparam int unsigned SEG  = WIDTH / STAGES;
   localparam int unsigned SUMW = SEG + 1;

   // The whole pipeline freezes while the output beat is refused.
   logic w_stall;
   assign w_stall  = out_valid && !out_ready;
   assign in_ready = !w_stall;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int unsigned IN_W   = WIDTH - k * SEG;
      localparam int unsigned DONE_W = (k + 1) * SEG;

      logic              w_src_v;
      logic              w_src_sub;
      logic              w_src_c;
      logic [IN_W-1:0]   w_src_a;
      logic [IN_W-1:0]   w_src_b;
      logic [SEG-1:0]    w_b_seg;
      logic [SEG:0]      w_seg_sum;
      logic [DONE_W-1:0] w_res;
      logic [DONE_W-1:0] w_out;

      logic              r_v;
      logic              r_c;
      logic [DONE_W-1:0] r_res;

      // Operand source: the input port for stage 0, the previous stage otherwise.
      if (k == 0) begin : g_src_in
         assign w_src_v   = in_valid;
         assign w_src_sub = sub;
         assign w_src_c   = sub;
         assign w_src_a   = a;
         assign w_src_b   = b;
         assign w_res     = w_seg_sum[SEG-1:0];
      end else begin : g_src_prev
         assign w_src_v   = g_stage[k-1].r_v;
         assign w_src_sub = g_stage[k-1].g_fwd.r_sub;
         assign w_src_c   = g_stage[k-1].r_c;
         assign w_src_a   = g_stage[k-1].g_fwd.r_a;
         assign w_src_b   = g_stage[k-1].g_fwd.r_b;
         assign w_res     = {w_seg_sum[SEG-1:0], g_stage[k-1].r_res};
      end

      // Segment k always sits in the low SEG bits of the remaining operand slice.
      assign w_b_seg   = w_src_b[SEG-1:0] ^ {SEG{w_src_sub}};
      assign w_seg_sum = {1'b0, w_src_a[SEG-1:0]} + {1'b0, w_b_seg} + SUMW'(w_src_c);

      if (k < STAGES - 1) begin : g_fwd
         localparam int unsigned FWD_W = IN_W - SEG;

         logic             r_sub;
         logic [FWD_W-1:0] r_a;
         logic [FWD_W-1:0] r_b;

         assign w_out = w_res;

         // Operand segments still waiting for a later stage.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_sub <= 1'b0;
               r_a   <= '0;
               r_b   <= '0;
            end else if (!w_stall && w_src_v) begin
               r_sub <= w_src_sub;
               r_a   <= w_src_a[IN_W-1:SEG];
               r_b   <= w_src_b[IN_W-1:SEG];
            end
         end
      end else begin : g_last
         logic w_b_msb;
         logic w_ovf;
         logic r_ovf;

         assign w_b_msb = w_src_b[IN_W-1] ^ w_src_sub;
         assign w_ovf   = (w_src_a[IN_W-1] == w_b_msb) && (w_res[WIDTH-1] != w_src_a[IN_W-1]);

`ifdef PIPELINED_ADDSUB_SAT_EN
         localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
         localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

         // Clamp toward the sign of a; cout and ovf still describe the raw sum.
         assign w_out = w_ovf ? (w_src_a[IN_W-1] ? SAT_NEG : SAT_POS) : w_res;
`else
         assign w_out = w_res;
`endif

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_ovf <= 1'b0;
            end else if (!w_stall && w_src_v) begin
               r_ovf <= w_ovf;
            end
         end
      end

      // Valid advances on every unstalled cycle; payload only loads with a real beat.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_v   <= 1'b0;
            r_c   <= 1'b0;
            r_res <= '0;
         end else if (!w_stall) begin
            r_v <= w_src_v;
            if (w_src_v) begin
               r_c   <= w_seg_sum[SEG];
               r_res <= w_out;
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].r_v;
   assign s         = g_stage[STAGES-1].r_res;
   assign cout      = g_stage[STAGES-1].r_c;
   assign ovf       = g_stage[STAGES-1].g_last.r_ovf;

endmodule
